// File: rtl/tc_sram_banked_pkg.sv
// rtl/tc_sram_banked_pkg.sv - shared types and address helpers for the banked SRAM
package tc_sram_banked_pkg;

  // Widest word the response pipeline can carry; narrower words are zero-extended.
  localparam int unsigned MaxDataWidth = 64;

  typedef struct packed {
    logic                    rvalid;
    logic [MaxDataWidth-1:0] rdata;
    logic                    perr;
  } resp_t;

  // Low address bits pick the bank (word interleaving).
  function automatic int unsigned bank_sel(input int unsigned addr, input int unsigned bank_sel_w);
    if (bank_sel_w == 0) return 0;
    return addr & ((32'd1 << bank_sel_w) - 32'd1);
  endfunction

  // Remaining upper bits pick the row inside the bank.
  function automatic int unsigned row_sel(input int unsigned addr, input int unsigned bank_sel_w);
    return addr >> bank_sel_w;
  endfunction

endpackage

// File: rtl/tc_sram_banked_rr_arb.sv
// rtl/tc_sram_banked_rr_arb.sv - per-bank round-robin arbiter with one-hot grant and winner index
module tc_sram_banked_rr_arb #(
  parameter int unsigned NumPorts = 4,
  parameter int unsigned IdxWidth = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumPorts-1:0] req,
  output logic [NumPorts-1:0] gnt,
  output logic [IdxWidth-1:0] idx,
  output logic                valid
);

  logic [IdxWidth-1:0] ptr;

  // Pick the first requester at or after the pointer, wrapping around.
  always_comb begin
    int unsigned cand;
    cand  = 0;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= NumPorts) cand = cand - NumPorts;
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IdxWidth'(cand);
      end
    end
  end

  // Move priority just past the winner, only when something was granted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr <= '0;
    end else if (valid) begin
      ptr <= (32'(idx) + 32'd1 >= NumPorts) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/tc_sram_banked.sv
// rtl/tc_sram_banked.sv - word-interleaved banked SRAM, req/gnt/rvalid; optional parity via TC_SRAM_BANKED_PARITY_EN
module tc_sram_banked
  import tc_sram_banked_pkg::*;
#(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned NumPorts  = 4,
  parameter int unsigned NumBanks  = 4,
  parameter int unsigned Latency   = 1,
  parameter string       SimInit   = "none",
  localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth,
  localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NumPorts-1:0]                  req_i,
  output logic [NumPorts-1:0]                  gnt_o,
  input  logic [NumPorts-1:0]                  we_i,
  input  logic [NumPorts-1:0][AddrWidth-1:0]   addr_i,
  input  logic [NumPorts-1:0][DataWidth-1:0]   wdata_i,
  input  logic [NumPorts-1:0][BeWidth-1:0]     be_i,
  output logic [NumPorts-1:0]                  rvalid_o,
  output logic [NumPorts-1:0][DataWidth-1:0]   rdata_o,
  output logic [NumPorts-1:0]                  perr_o
);

  localparam int unsigned BankSelW = $clog2(NumBanks);
  localparam int unsigned Rows     = NumWords / NumBanks;
  localparam int unsigned RowIdxW  = (Rows > 1) ? $clog2(Rows) : 1;
  localparam int unsigned BankIdxW = (NumBanks > 1) ? $clog2(NumBanks) : 1;
  localparam int unsigned IdxWidth = (NumPorts > 1) ? $clog2(NumPorts) : 1;

  logic [DataWidth-1:0] mem [NumBanks][Rows];
`ifdef TC_SRAM_BANKED_PARITY_EN
  logic [BeWidth-1:0]   pmem [NumBanks][Rows];
  logic [NumPorts-1:0][BeWidth-1:0] wpar;

  function automatic logic [BeWidth-1:0] parity(input logic [DataWidth-1:0] d);
    logic [BeWidth-1:0] p;
    p = '0;
    for (int unsigned i = 0; i < DataWidth; i++) p[i / ByteWidth] = p[i / ByteWidth] ^ d[i];
    return p;
  endfunction
`endif

  logic [NumBanks-1:0][NumPorts-1:0] bank_req;
  logic [NumBanks-1:0][NumPorts-1:0] bank_gnt;
  logic [NumBanks-1:0][IdxWidth-1:0] bank_idx;
  logic [NumBanks-1:0]               bank_valid;
  logic [NumPorts-1:0][BankIdxW-1:0] port_bank;
  logic [NumPorts-1:0][RowIdxW-1:0]  port_row;
  logic [NumPorts-1:0]               port_in_range;
  logic [NumPorts-1:0][DataWidth-1:0] rd_data;
  logic [NumPorts-1:0]               rd_perr;
  resp_t                             pipe [NumPorts][Latency];

  // Decode each port address and steer its request to the owning bank.
  always_comb begin
    int unsigned a, r, b;
    a = 0; r = 0; b = 0;
    bank_req      = '0;
    port_bank     = '0;
    port_row      = '0;
    port_in_range = '0;
    for (int unsigned p = 0; p < NumPorts; p++) begin
      a = 32'(addr_i[p]);
      b = bank_sel(a, BankSelW);
      r = row_sel(a, BankSelW);
      port_bank[p]     = BankIdxW'(b);
      port_row[p]      = RowIdxW'(r);
      port_in_range[p] = (r < Rows);
      bank_req[b][p]   = req_i[p];
    end
  end

  for (genvar gb = 0; gb < NumBanks; gb++) begin : g_bank
    tc_sram_banked_rr_arb #(
      .NumPorts(NumPorts),
      .IdxWidth(IdxWidth)
    ) u_arb (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .req   (bank_req[gb]),
      .gnt   (bank_gnt[gb]),
      .idx   (bank_idx[gb]),
      .valid (bank_valid[gb])
    );
  end

  // A port only ever targets one bank, so OR-ing bank grants gives its grant.
  always_comb begin
    gnt_o = '0;
    for (int unsigned b = 0; b < NumBanks; b++) gnt_o = gnt_o | bank_gnt[b];
  end

  // Read the addressed word; out-of-range reads return zero.
  always_comb begin
    rd_data = '0;
    rd_perr = '0;
`ifdef TC_SRAM_BANKED_PARITY_EN
    wpar    = '0;
`endif
    for (int unsigned p = 0; p < NumPorts; p++) begin
`ifdef TC_SRAM_BANKED_PARITY_EN
      wpar[p] = parity(wdata_i[p]);
`endif
      if (port_in_range[p]) begin
        rd_data[p] = mem[port_bank[p]][port_row[p]];
`ifdef TC_SRAM_BANKED_PARITY_EN
        rd_perr[p] = |(parity(rd_data[p]) ^ pmem[port_bank[p]][port_row[p]]);
`else
        rd_perr[p] = 1'b0;
`endif
      end
    end
  end

  // Commit granted writes byte-wise; reset deliberately leaves contents alone.
  always_ff @(posedge clk_i) begin
    for (int unsigned b = 0; b < NumBanks; b++) begin
      if (bank_valid[b] && we_i[bank_idx[b]] && port_in_range[bank_idx[b]]) begin
        for (int unsigned i = 0; i < DataWidth; i++) begin
          if (be_i[bank_idx[b]][i / ByteWidth])
            mem[b][port_row[bank_idx[b]]][i] <= wdata_i[bank_idx[b]][i];
        end
`ifdef TC_SRAM_BANKED_PARITY_EN
        for (int unsigned k = 0; k < BeWidth; k++) begin
          if (be_i[bank_idx[b]][k]) pmem[b][port_row[bank_idx[b]]][k] <= wpar[bank_idx[b]][k];
        end
`endif
      end
    end
  end

  // Fixed-depth response pipeline; rdata only moves with a valid beat so outputs hold.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned p = 0; p < NumPorts; p++)
        for (int unsigned s = 0; s < Latency; s++) pipe[p][s] <= '0;
    end else begin
      for (int unsigned p = 0; p < NumPorts; p++) begin
        pipe[p][0].rvalid <= gnt_o[p] & ~we_i[p];
        pipe[p][0].perr   <= gnt_o[p] & ~we_i[p] & rd_perr[p];
        if (gnt_o[p] && !we_i[p]) pipe[p][0].rdata <= MaxDataWidth'(rd_data[p]);
        for (int unsigned s = 1; s < Latency; s++) begin
          pipe[p][s].rvalid <= pipe[p][s-1].rvalid;
          pipe[p][s].perr   <= pipe[p][s-1].perr;
          if (pipe[p][s-1].rvalid) pipe[p][s].rdata <= pipe[p][s-1].rdata;
        end
      end
    end
  end

  // Last pipeline stage drives the response outputs.
  always_comb begin
    for (int unsigned p = 0; p < NumPorts; p++) begin
      rvalid_o[p] = pipe[p][Latency-1].rvalid;
      rdata_o[p]  = pipe[p][Latency-1].rdata[DataWidth-1:0];
`ifdef TC_SRAM_BANKED_PARITY_EN
      perr_o[p]   = pipe[p][Latency-1].perr;
`else
      perr_o[p]   = 1'b0;
`endif
    end
  end

`ifndef SYNTHESIS
  localparam bit SimInitOk = (SimInit == "zeros") || (SimInit == "ones") ||
                             (SimInit == "random") || (SimInit == "none");
  localparam bit ParamsOk  = (Latency >= 1) && (NumBanks >= 1) &&
                             ((NumBanks & (NumBanks - 1)) == 0) &&
                             (NumWords % NumBanks == 0) && (DataWidth <= MaxDataWidth) && SimInitOk;

  a_params : assert property (@(posedge clk_i) ParamsOk);

  for (genvar gp = 0; gp < NumPorts; gp++) begin : g_chk
    a_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
      req_i[gp] |-> (32'(addr_i[gp]) < NumWords))
      else $warning("tc_sram_banked: port %0d address out of range", gp);
    a_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (req_i[gp] && $past(req_i[gp] && !gnt_o[gp])) |->
      $stable({we_i[gp], addr_i[gp], wdata_i[gp], be_i[gp]}));
  end
`endif

endmodule

// File: tb/tb_tc_sram_banked.sv
// tb/tb_tc_sram_banked.sv - directed self-checking bench for tc_sram_banked
module tb_tc_sram_banked;

  localparam int unsigned LAT = 1;
`ifdef TC_SRAM_BANKED_PARITY_EN
  localparam logic PERR_EXP = 1'b1;
`else
  localparam logic PERR_EXP = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic [3:0]        req_i = '0;
  logic [3:0]        gnt_o;
  logic [3:0]        we_i = '0;
  logic [3:0][9:0]   addr_i = '0;
  logic [3:0][31:0]  wdata_i = '0;
  logic [3:0][3:0]   be_i = '0;
  logic [3:0]        rvalid_o;
  logic [3:0][31:0]  rdata_o;
  logic [3:0]        perr_o;

  int checks = 0;
  int errors = 0;

  tc_sram_banked #(
    .NumWords (1024),
    .DataWidth(32),
    .ByteWidth(8),
    .NumPorts (4),
    .NumBanks (4),
    .Latency  (LAT),
    .SimInit  ("none")
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_i   (req_i),
    .gnt_o   (gnt_o),
    .we_i    (we_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .be_i    (be_i),
    .rvalid_o(rvalid_o),
    .rdata_o (rdata_o),
    .perr_o  (perr_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic set_req(input int p, input logic we, input logic [9:0] a,
                         input logic [31:0] d, input logic [3:0] be);
    req_i[p] = 1'b1; we_i[p] = we; addr_i[p] = a; wdata_i[p] = d; be_i[p] = be;
  endtask

  task automatic clr_req(input int p);
    req_i[p] = 1'b0;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    req_i  = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checks++; if (rvalid_o !== 4'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected %b", rvalid_o, 4'b0); end
    checks++; if (rdata_o !== '0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata_o); end
    checks++; if (perr_o !== 4'b0) begin errors++; $display("FAIL reset_perr: got %b expected %b", perr_o, 4'b0); end
    checks++; if (gnt_o !== 4'b0) begin errors++; $display("FAIL reset_gnt: got %b expected %b", gnt_o, 4'b0); end
    rst_ni = 1'b1;
  endtask

  task automatic test_write_read;
    @(negedge clk_i); set_req(0, 1'b1, 10'h005, 32'hDEADBEEF, 4'hF); #1;
    checks++; if (gnt_o !== 4'b0001) begin errors++; $display("FAIL wr_gnt: got %b expected %b", gnt_o, 4'b0001); end
    @(negedge clk_i); set_req(0, 1'b0, 10'h005, 32'h0, 4'h0); #1;
    checks++; if (gnt_o !== 4'b0001) begin errors++; $display("FAIL rd_gnt: got %b expected %b", gnt_o, 4'b0001); end
    checks++; if (rvalid_o !== 4'b0000) begin errors++; $display("FAIL wr_no_rvalid: got %b expected %b", rvalid_o, 4'b0000); end
    @(negedge clk_i); clr_req(0);
    repeat (LAT - 1) @(negedge clk_i);
    checks++; if (rvalid_o !== 4'b0001) begin errors++; $display("FAIL rd_rvalid: got %b expected %b", rvalid_o, 4'b0001); end
    checks++; if (rdata_o[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h expected %h", rdata_o[0], 32'hDEADBEEF); end
    checks++; if (perr_o[0] !== 1'b0) begin errors++; $display("FAIL rd_perr_clean: got %b expected %b", perr_o[0], 1'b0); end
    @(negedge clk_i);
    checks++; if (rvalid_o !== 4'b0000) begin errors++; $display("FAIL rvalid_drop: got %b expected %b", rvalid_o, 4'b0000); end
    checks++; if (rdata_o[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL rdata_hold: got %h expected %h", rdata_o[0], 32'hDEADBEEF); end
  endtask

  task automatic test_byte_enable;
    @(negedge clk_i); set_req(2, 1'b1, 10'h010, 32'h11223344, 4'hF);
    @(negedge clk_i); set_req(2, 1'b1, 10'h010, 32'h0000AB00, 4'b0010);
    @(negedge clk_i); set_req(2, 1'b1, 10'h010, 32'hFFFFFFFF, 4'b0000); #1;
    checks++; if (gnt_o !== 4'b0100) begin errors++; $display("FAIL be0_gnt: got %b expected %b", gnt_o, 4'b0100); end
    @(negedge clk_i); set_req(2, 1'b0, 10'h010, 32'h0, 4'h0);
    @(negedge clk_i); clr_req(2);
    checks++; if (rvalid_o !== 4'b0100) begin errors++; $display("FAIL be_rvalid: got %b expected %b", rvalid_o, 4'b0100); end
    checks++; if (rdata_o[2] !== 32'h1122AB44) begin errors++; $display("FAIL be_data: got %h expected %h", rdata_o[2], 32'h1122AB44); end
  endtask

  task automatic test_parallel;
    @(negedge clk_i);
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 10'(i), 32'h10000000 + 32'(i) * 32'h0101, 4'hF);
    #1;
    checks++; if (gnt_o !== 4'b1111) begin errors++; $display("FAIL par_wr_gnt: got %b expected %b", gnt_o, 4'b1111); end
    @(negedge clk_i);
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 10'(i), 32'h0, 4'h0);
    #1;
    checks++; if (gnt_o !== 4'b1111) begin errors++; $display("FAIL par_rd_gnt: got %b expected %b", gnt_o, 4'b1111); end
    @(negedge clk_i);
    for (int i = 0; i < 4; i++) clr_req(i);
    checks++; if (rvalid_o !== 4'b1111) begin errors++; $display("FAIL par_rvalid: got %b expected %b", rvalid_o, 4'b1111); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rdata_o[i] !== 32'h10000000 + 32'(i) * 32'h0101) begin
        errors++; $display("FAIL par_data%0d: got %h expected %h", i, rdata_o[i], 32'h10000000 + 32'(i) * 32'h0101);
      end
    end
  endtask

  task automatic test_conflict;
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i); rst_ni = 1'b1;
    @(negedge clk_i);
    set_req(0, 1'b1, 10'h000, 32'hC0C00000, 4'hF);
    set_req(1, 1'b1, 10'h004, 32'hC4C40004, 4'hF);
    set_req(2, 1'b1, 10'h008, 32'hC8C80008, 4'hF);
    #1;
    checks++; if (gnt_o !== 4'b0001) begin errors++; $display("FAIL cf_gnt_p0: got %b expected %b", gnt_o, 4'b0001); end
    @(negedge clk_i); clr_req(0); #1;
    checks++; if (gnt_o !== 4'b0010) begin errors++; $display("FAIL cf_gnt_p1: got %b expected %b", gnt_o, 4'b0010); end
    @(negedge clk_i); clr_req(1); #1;
    checks++; if (gnt_o !== 4'b0100) begin errors++; $display("FAIL cf_gnt_p2: got %b expected %b", gnt_o, 4'b0100); end
    @(negedge clk_i); clr_req(2);
    set_req(0, 1'b0, 10'h008, 32'h0, 4'h0);
    set_req(3, 1'b0, 10'h004, 32'h0, 4'h0);
    #1;
    checks++; if (gnt_o !== 4'b1000) begin errors++; $display("FAIL cf_gnt_p3: got %b expected %b", gnt_o, 4'b1000); end
    @(negedge clk_i); clr_req(3); #1;
    checks++; if (gnt_o !== 4'b0001) begin errors++; $display("FAIL cf_gnt_wrap_p0: got %b expected %b", gnt_o, 4'b0001); end
    checks++; if (rvalid_o !== 4'b1000) begin errors++; $display("FAIL cf_rvalid_p3: got %b expected %b", rvalid_o, 4'b1000); end
    checks++; if (rdata_o[3] !== 32'hC4C40004) begin errors++; $display("FAIL cf_data_p3: got %h expected %h", rdata_o[3], 32'hC4C40004); end
    @(negedge clk_i); clr_req(0);
    checks++; if (rvalid_o !== 4'b0001) begin errors++; $display("FAIL cf_rvalid_p0: got %b expected %b", rvalid_o, 4'b0001); end
    checks++; if (rdata_o[0] !== 32'hC8C80008) begin errors++; $display("FAIL cf_data_p0: got %h expected %h", rdata_o[0], 32'hC8C80008); end
  endtask

  task automatic test_reset_inflight;
    @(negedge clk_i); set_req(1, 1'b0, 10'h005, 32'h0, 4'h0); #1;
    checks++; if (gnt_o !== 4'b0010) begin errors++; $display("FAIL rst_rd_gnt: got %b expected %b", gnt_o, 4'b0010); end
    @(posedge clk_i); #1;
    rst_ni = 1'b0; #1;
    checks++; if (rvalid_o !== 4'b0000) begin errors++; $display("FAIL rst_async_clear: got %b expected %b", rvalid_o, 4'b0000); end
    @(negedge clk_i); clr_req(1);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checks++; if (rvalid_o !== 4'b0000) begin errors++; $display("FAIL rst_no_rvalid%0d: got %b expected %b", i, rvalid_o, 4'b0000); end
    end
    @(negedge clk_i); set_req(1, 1'b0, 10'h005, 32'h0, 4'h0);
    @(negedge clk_i); clr_req(1);
    checks++; if (rdata_o[1] !== 32'hDEADBEEF) begin errors++; $display("FAIL rst_array_kept: got %h expected %h", rdata_o[1], 32'hDEADBEEF); end
  endtask

  task automatic test_parity;
    @(negedge clk_i); set_req(1, 1'b1, 10'h00A, 32'hA5A5A5A5, 4'hF);
    @(negedge clk_i); clr_req(1);
    dut.mem[2][2] = dut.mem[2][2] ^ 32'h00000200;
    @(negedge clk_i); set_req(1, 1'b0, 10'h00A, 32'h0, 4'h0);
    @(negedge clk_i); clr_req(1);
    checks++; if (rvalid_o !== 4'b0010) begin errors++; $display("FAIL par_rvalid: got %b expected %b", rvalid_o, 4'b0010); end
    checks++; if (rdata_o[1] !== 32'hA5A5A7A5) begin errors++; $display("FAIL par_flip_data: got %h expected %h", rdata_o[1], 32'hA5A5A7A5); end
    checks++; if (perr_o[1] !== PERR_EXP) begin errors++; $display("FAIL par_perr: got %b expected %b", perr_o[1], PERR_EXP); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_parallel();
    test_conflict();
    test_reset_inflight();
    test_parity();
    repeat (2) @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
